// File: rtl/fp_pkg.sv
// Shared constants, inter-stage bundle and helpers for the
// floating-point multiply exception unit.
package fp_pkg;

   localparam int B16_EXP_W = 5;
   localparam int B16_MAN_W = 10;
   localparam int B32_EXP_W = 8;
   localparam int B32_MAN_W = 23;
   localparam int B64_EXP_W = 11;
   localparam int B64_MAN_W = 52;

   localparam int INV = 2;
   localparam int OVF = 1;
   localparam int ZRO = 0;

   localparam int PAT_W = 64;

   typedef struct packed {
      logic x_zero;
      logic x_inf;
      logic x_nan;
      logic y_zero;
      logic y_inf;
      logic y_nan;
      logic ez_ovf;
      logic ovf_case;
      logic sz;
   } s1_t;

   function automatic logic [PAT_W-1:0] qnan_pat(
      input int exp_w,
      input int man_w
   );
      logic [PAT_W-1:0] r;
      r = '0;
      for (int i = 0; i < exp_w; i++)
         r[man_w+i] = 1'b1;
      r[man_w-1] = 1'b1;
      return r;
   endfunction

endpackage

// File: rtl/fp_mul_exc_classify.sv
// Operand classifier: zero, infinity and NaN detection
// from the exponent and stored mantissa fields.
module fp_classify
   import fp_pkg::*;
#(
   parameter int EXP_W = B32_EXP_W,
   parameter int MAN_W = B32_MAN_W
) (
   input  logic [EXP_W-1:0] expo,
   input  logic [MAN_W-1:0] man,
   output logic             is_zero,
   output logic             is_inf,
   output logic             is_nan
);

   logic exp_zero;
   logic exp_ones;
   logic man_zero;

   assign exp_zero = (expo == '0);
   assign exp_ones = &expo;
   assign man_zero = (man == '0);

   assign is_zero = exp_zero & man_zero;
   assign is_inf  = exp_ones & man_zero;
   assign is_nan  = exp_ones & ~man_zero;

endmodule

// File: rtl/fp_mul_exc_unit.sv
// Two-stage exception/special-result unit for an FP multiplier.
// Optional sticky flag register: FP_MUL_EXC_STICKY_EN.
module fp_mul_exc_unit
   import fp_pkg::*;
#(
   parameter int EXP_W = B32_EXP_W,
   parameter int MAN_W = B32_MAN_W
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic                   sx,
   input  logic                   sy,
   input  logic [EXP_W-1:0]       ex,
   input  logic [EXP_W-1:0]       ey,
   input  logic [EXP_W-1:0]       ez,
   input  logic [MAN_W-1:0]       mx,
   input  logic [MAN_W-1:0]       my,
   input  logic [MAN_W:0]         mz,
   input  logic                   ovf_case,
   input  logic                   flag_clr,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic                   invalid_flag,
   output logic                   overflow_flag,
   output logic                   zero_flag,
   output logic                   special_vld,
   output logic [EXP_W+MAN_W:0]   special_res,
   output logic [2:0]             sticky_flags
);

   localparam int W = 1 + EXP_W + MAN_W;
   localparam logic [PAT_W-1:0] QNAN_FULL = qnan_pat(EXP_W, MAN_W);
   localparam logic [W-1:0] QNAN = QNAN_FULL[W-1:0];

   logic x_zero, x_inf, x_nan;
   logic y_zero, y_inf, y_nan;

   s1_t        s1_d;
   s1_t        s1;
   logic       v1;
   logic       v2;
   logic       adv1;
   logic       adv2;
   logic       xfer;
   logic [2:0] flags_c;
   logic [2:0] flags2;
   logic [W-1:0] res_c;
   logic [W-1:0] res2;

   fp_classify #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_cls_x (
      .expo    (ex),
      .man     (mx),
      .is_zero (x_zero),
      .is_inf  (x_inf),
      .is_nan  (x_nan)
   );

   fp_classify #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_cls_y (
      .expo    (ey),
      .man     (my),
      .is_zero (y_zero),
      .is_inf  (y_inf),
      .is_nan  (y_nan)
   );

   assign adv2     = ~v2 | out_ready;
   assign adv1     = ~v1 | adv2;
   assign in_ready = adv1;
   assign xfer     = v2 & out_ready;

   assign s1_d.x_zero   = x_zero;
   assign s1_d.x_inf    = x_inf;
   assign s1_d.x_nan    = x_nan;
   assign s1_d.y_zero   = y_zero;
   assign s1_d.y_inf    = y_inf;
   assign s1_d.y_nan    = y_nan;
   assign s1_d.ez_ovf   = (&ez) & (mz == '0);
   assign s1_d.ovf_case = ovf_case;
   assign s1_d.sz       = sx ^ sy;

   // Stage 1: capture classification bits on acceptance
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v1 <= 1'b0;
         s1 <= '0;
      end else if (adv1) begin
         v1 <= in_valid;
         if (in_valid)
            s1 <= s1_d;
      end
   end

   // Flag priority inv > ovf > zro and the matching canonical result
   always_comb begin
      flags_c = '0;
      res_c   = '0;
      flags_c[INV] = (s1.x_zero & s1.y_inf) | (s1.x_inf & s1.y_zero)
                   | s1.x_nan | s1.y_nan;
      flags_c[OVF] = ~flags_c[INV]
                   & (s1.ez_ovf | (s1.x_inf & ~s1.y_zero)
                   | (~s1.x_zero & s1.y_inf) | s1.ovf_case);
      flags_c[ZRO] = ~flags_c[INV] & ~flags_c[OVF]
                   & ((s1.x_zero & ~s1.y_inf)
                   | (~s1.x_inf & s1.y_zero));
      unique case (1'b1)
         flags_c[INV]: res_c = QNAN;
         flags_c[OVF]: res_c = {s1.sz, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
         flags_c[ZRO]: res_c = {s1.sz, {(EXP_W+MAN_W){1'b0}}};
         default:      res_c = '0;
      endcase
   end

   // Stage 2: register flags and special result, hold under backpressure
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v2     <= 1'b0;
         flags2 <= '0;
         res2   <= '0;
      end else if (adv2) begin
         v2 <= v1;
         if (v1) begin
            flags2 <= flags_c;
            res2   <= res_c;
         end
      end
   end

   assign out_valid     = v2;
   assign invalid_flag  = flags2[INV];
   assign overflow_flag = flags2[OVF];
   assign zero_flag     = flags2[ZRO];
   assign special_vld   = |flags2;
   assign special_res   = res2;

`ifdef FP_MUL_EXC_STICKY_EN
   logic [2:0] sticky_q;

   // Clear first, then OR in the flags of a result leaving this cycle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         sticky_q <= '0;
      else if (flag_clr)
         sticky_q <= xfer ? flags2 : 3'b000;
      else if (xfer)
         sticky_q <= sticky_q | flags2;
   end

   assign sticky_flags = sticky_q;
`else
   logic unused_sticky_in;
   assign unused_sticky_in = flag_clr ^ xfer;
   assign sticky_flags     = 3'b000;
`endif

endmodule
